uart_line_echo: RTL and testbench

- Sits directly downstream of the uart receiver and upstream of the uart transmitter.
- Collects received bytes into a line buffer until a terminator byte arrives, then replays the buffered line followed by CR LF through the transmit handshake.
- Gives the board an interactive line-echo path, replacing fixed-greeting transmit logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_sequencer.sv | 55 +++++
 rtl/uart_line_echo.sv | 173 +++++++++++++++++
 tb/tb_uart_line_echo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART character constants and line-echo state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Control characters used by the line echo path.
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

    // Line echo state encoding.
    localparam int              ST_W    = 2;
    localparam logic [ST_W-1:0] COLLECT = 2'd0;
    localparam logic [ST_W-1:0] SEND    = 2'd1;
    localparam logic [ST_W-1:0] HOLD    = 2'd2;
    localparam logic [ST_W-1:0] DONE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sequencer
// Description : Turns a byte valid/ready handshake into single-cycle transmit
//               requests for the UART transmitter. A byte is accepted only
//               when the transmitter is idle and the one-cycle hold-off that
//               follows every request has elapsed, so requests are never
//               back to back and never issued while the UART is busy.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               i_valid, i_byte        - upstream byte offer
//               o_ready                - byte accepted this cycle when valid
//               i_is_transmitting      - UART transmitter busy
//               o_transmit, o_tx_byte  - registered request to the UART
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    input  logic       i_is_transmitting,
    output logic       o_transmit,
    output logic [7:0] o_tx_byte
);

    logic       r_hold;
    logic       r_transmit;
    logic [7:0] r_tx_byte;
    logic       w_accept;

    // The UART raises its busy flag one cycle after the request, so the cycle
    // right after a request is blocked regardless of i_is_transmitting.
    assign o_ready  = !r_hold && !i_is_transmitting;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= 1'b0;
            r_transmit <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            r_transmit <= w_accept;
            r_hold     <= w_accept;
            if (w_accept) begin
                r_tx_byte <= i_byte;
            end
        end
    end

    assign o_transmit = r_transmit;
    assign o_tx_byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: rtl/uart_line_echo.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_echo
// Description : Collects UART receive bytes into a line buffer until the
//               terminator arrives, then replays the line followed by CR LF
//               through the UART transmit handshake.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               received, rx_byte - receive strobe and byte from the UART
//               recv_error        - receive framing error strobe (byte invalid)
//               is_transmitting   - UART transmitter busy
//               transmit, tx_byte - single-cycle transmit request and byte
//               line_ready        - pulse when a terminator is accepted
//               overflow          - sticky: a byte of this line was dropped
//               busy              - high whenever not collecting
// Options     : UART_LINE_BACKSPACE_EN - when defined, BS (08) and DEL (7F)
//               erase the last buffered byte instead of being stored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_echo
    import uart_pkg::*;
#(
    parameter int         LINE_MAX  = 32,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       line_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int              CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_line_max = CNT_W'(LINE_MAX);

    logic [7:0]       r_mem [LINE_MAX];
    logic [ST_W-1:0]  r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rd_idx;
    logic             r_line_ready;
    logic             r_overflow;
    logic             r_busy;

    logic             w_rx_ok;
    logic             w_is_term;
    logic             w_is_edit;
    logic             w_mem_we;
    logic [7:0]       w_tx_data;
    logic             w_tx_valid;
    logic             w_tx_ready;
    logic             w_accept;

    // A framing error invalidates the byte even if received is also high.
    assign w_rx_ok   = received && !recv_error;
    assign w_is_term = (rx_byte == TERM_CHAR);

`ifdef UART_LINE_BACKSPACE_EN
    assign w_is_edit = (rx_byte == CHAR_BS) || (rx_byte == CHAR_DEL);
`else
    assign w_is_edit = 1'b0;
`endif

    assign w_mem_we = (r_state == COLLECT) && w_rx_ok && !w_is_term &&
                      !w_is_edit && (r_count < c_line_max);

    // Replay order: buffered bytes, then CR, then LF.
    always_comb begin
        w_tx_data = CHAR_LF;
        if (r_rd_idx < r_count) begin
            w_tx_data = r_mem[r_rd_idx[ADDR_W-1:0]];
        end else if (r_rd_idx == r_count) begin
            w_tx_data = CHAR_CR;
        end
    end

    assign w_tx_valid = (r_state == SEND);
    assign w_accept   = w_tx_valid && w_tx_ready;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_count[ADDR_W-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_count      <= '0;
            r_rd_idx     <= '0;
            r_line_ready <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_line_ready <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_rx_ok) begin
                        if (w_is_term) begin
                            r_line_ready <= 1'b1;
                            r_rd_idx     <= '0;
                            r_state      <= SEND;
                            r_busy       <= 1'b1;
                        end else if (w_is_edit) begin
                            if (r_count != '0) begin
                                r_count <= r_count - CNT_W'(1);
                            end
                        end else if (r_count < c_line_max) begin
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_rx_ok) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_accept) begin
                        r_rd_idx <= r_rd_idx + CNT_W'(1);
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_rx_ok) begin
                        r_overflow <= 1'b1;
                    end
                    // After the LF (index count+1) has been issued the index
                    // sits at count+2.
                    if (r_rd_idx == r_count + CNT_W'(2)) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= SEND;
                    end
                end
                DONE: begin
                    // Clear the finished line's flag; a byte dropped in this
                    // very cycle still marks the new line.
                    r_count    <= '0;
                    r_overflow <= w_rx_ok;
                    r_state    <= COLLECT;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= COLLECT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_sequencer u_tx_seq (
        .clk               (clk),
        .rst               (rst),
        .i_valid           (w_tx_valid),
        .i_byte            (w_tx_data),
        .o_ready           (w_tx_ready),
        .i_is_transmitting (is_transmitting),
        .o_transmit        (transmit),
        .o_tx_byte         (tx_byte)
    );

    assign line_ready = r_line_ready;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_echo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_line_echo
// Description : Self-checking bench for uart_line_echo. Stimulus pushes the
//               expected replay bytes into a queue; a monitor pops and
//               compares on every transmit pulse. The UART transmitter is
//               modelled as busy for 10 cycles starting one cycle after each
//               transmit request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_line_echo;

    logic       clk = 1'b0;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       line_ready;
    logic       overflow;
    logic       busy;

    int         errors   = 0;
    int         checks   = 0;
    int         tx_count = 0;
    int         lr_count = 0;
    int         busy_cnt = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_line_echo dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .line_ready      (line_ready),
        .overflow        (overflow),
        .busy            (busy)
    );

    // UART transmitter model.
    always @(posedge clk) begin
        if (transmit) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign is_transmitting = (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic prev_tx;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (transmit) begin
                    tx_count++;
                    chk("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
                    chk("tx_back_to_back", {31'd0, prev_tx}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", tx_byte);
                    end else begin
                        chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
                if (line_ready) lr_count++;
            end
            prev_tx = transmit;
        end
    end

    task automatic send(input logic [7:0] b, input logic err);
        @(posedge clk); #1;
        received   = 1'b1;
        recv_error = err;
        rx_byte    = b;
        @(posedge clk); #1;
        received   = 1'b0;
        recv_error = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || is_transmitting) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got timeout expected idle, %0d bytes pending", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        rst        = 1'b1;
        received   = 1'b0;
        recv_error = 1'b0;
        rx_byte    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_transmit",   {31'd0, transmit},   32'd0);
        chk("rst_tx_byte",    {24'd0, tx_byte},    32'd0);
        chk("rst_line_ready", {31'd0, line_ready}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        rst = 1'b0;

        // "abc" CR
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0);
        send(8'h0D, 1'b0);
        chk("line_ready_pulse", {31'd0, line_ready}, 32'd1);
        chk("busy_after_term",  {31'd0, busy},       32'd1);
        @(posedge clk); #1;
        chk("latency_transmit", {31'd0, transmit},   32'd1);
        chk("latency_byte",     {24'd0, tx_byte},    32'h61);
        chk("line_ready_once",  {31'd0, line_ready}, 32'd0);
        wait_done();
        chk("lr_count_abc", lr_count, 32'd1);

        // Terminator only
        base = tx_count;
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h0D, 1'b0);
        wait_done();
        chk("empty_line_tx_count", tx_count - base, 32'd2);
        chk("empty_line_busy", {31'd0, busy}, 32'd0);

        // 40 x 'A' with a 32-byte buffer
        for (int i = 0; i < 32; i++) exp_q.push_back(8'h41);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        for (int i = 0; i < 32; i++) send(8'h41, 1'b0);
        chk("ovf_at_32", {31'd0, overflow}, 32'd0);
        send(8'h41, 1'b0);
        chk("ovf_at_33", {31'd0, overflow}, 32'd1);
        for (int i = 33; i < 40; i++) send(8'h41, 1'b0);
        send(8'h0D, 1'b0);
        chk("ovf_in_replay", {31'd0, overflow}, 32'd1);
        wait_done();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // recv_error wins over received
        exp_q.push_back(8'h78); exp_q.push_back(8'h79);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h78, 1'b0); send(8'h55, 1'b1); send(8'h79, 1'b0);
        chk("err_no_ovf", {31'd0, overflow}, 32'd0);
        send(8'h0D, 1'b0);
        wait_done();

        // Reset during replay after two bytes sent
        base = tx_count;
        exp_q.push_back(8'h70); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
        exp_q.push_back(8'h73); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h70, 1'b0); send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b0);
        send(8'h0D, 1'b0);
        n = 0;
        while (tx_count < base + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_two_tx: got %0d transmits expected 2", tx_count - base);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_transmit", {31'd0, transmit}, 32'd0);
        chk("rst_mid_busy",     {31'd0, busy},     32'd0);
        rst = 1'b0;
        exp_q.delete();

        // New line after reset: count must restart at 0
        exp_q.push_back(8'h7A); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h7A, 1'b0); send(8'h0D, 1'b0);
        wait_done();

        // Backspace handling
        exp_q.push_back(8'h61);
`ifdef UART_LINE_BACKSPACE_EN
        exp_q.push_back(8'h63);
`else
        exp_q.push_back(8'h62); exp_q.push_back(8'h08); exp_q.push_back(8'h63);
`endif
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h08, 1'b0); send(8'h63, 1'b0);
        send(8'h0D, 1'b0);
        wait_done();
        chk("bs_no_ovf", {31'd0, overflow}, 32'd0);

        chk("lr_count_total", lr_count, 32'd7);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
